switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer.sv | 81 ++++++++
 tb/tb_switch_debouncer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: two-flop synchroniser per bit, then a per-bit stability
// counter that accepts a new level only after STABLE_COUNT consecutive mismatched samples.
module switch_debouncer #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned STABLE_COUNT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic             changed,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic             changed_q;
    logic             changed_d;
    logic             busy_q;
    logic             busy_d;

    // Per-bit qualification; a matching sample discards any partial run.
    always_comb begin
        clean_d   = clean_q;
        changed_d = 1'b0;
        busy_d    = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sample_en) begin
                if (sync2_q[i] == clean_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                    changed_d  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            if (cnt_d[i] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    // busy is registered from next-state counters so it tracks cnt_q exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            clean_q   <= '0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            clean_q   <= clean_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_clean = clean_q;
    assign changed  = changed_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: two instances (stability 4 and 1) on shared inputs,
// checked every cycle against a sample-history model plus directed edge checks.
module tb_switch_debouncer;

    logic       clk;
    logic       reset_n;
    logic       sample_en;
    logic [7:0] sw_raw;
    logic [7:0] clean4;
    logic [7:0] clean1;
    logic       chg4;
    logic       chg1;
    logic       busy4;
    logic       busy1;

    int n_total;
    int n_bad;

    switch_debouncer #(.WIDTH(8), .STABLE_COUNT(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .sw_raw(sw_raw),
        .sw_clean(clean4), .changed(chg4), .busy(busy4)
    );

    switch_debouncer #(.WIDTH(8), .STABLE_COUNT(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .sw_raw(sw_raw),
        .sw_clean(clean1), .changed(chg1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: keeps each bit's sampled history; a bit flips when its last N samples
    // since the previous acceptance all disagree with the accepted level.
    logic [7:0]  m_s1;
    logic [7:0]  m_s2;
    logic [7:0]  m_clean [2];
    logic [63:0] hist    [2][8];
    int          nsince  [2][8];
    logic        m_chg   [2];
    logic        m_busy  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        for (int k = 0; k < 2; k++) begin
            m_clean[k] = '0;
            m_chg[k]   = 1'b0;
            m_busy[k]  = 1'b0;
            for (int i = 0; i < 8; i++) begin
                hist[k][i]   = '0;
                nsince[k][i] = 0;
            end
        end
    endtask

    task automatic model_edge();
        int          n;
        logic [63:0] mask;
        logic        s;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            n         = (k == 0) ? 4 : 1;
            mask      = (64'(1) << n) - 64'(1);
            m_chg[k]  = 1'b0;
            m_busy[k] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (sample_en) begin
                    s            = m_s2[i];
                    hist[k][i]   = {hist[k][i][62:0], s};
                    nsince[k][i] = nsince[k][i] + 1;
                    if (nsince[k][i] >= n &&
                        ((hist[k][i] ^ {64{m_clean[k][i]}}) & mask) == mask) begin
                        m_clean[k][i] = s;
                        nsince[k][i]  = 0;
                        m_chg[k]      = 1'b1;
                    end
                end
                if (nsince[k][i] > 0 && hist[k][i][0] != m_clean[k][i]) begin
                    m_busy[k] = 1'b1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = sw_raw;
    endtask

    task automatic check_all();
        chk("clean4",   32'(clean4), 32'(m_clean[0]));
        chk("changed4", 32'(chg4),   32'(m_chg[0]));
        chk("busy4",    32'(busy4),  32'(m_busy[0]));
        chk("clean1",   32'(clean1), 32'(m_clean[1]));
        chk("changed1", 32'(chg1),   32'(m_chg[1]));
        chk("busy1",    32'(busy1),  32'(m_busy[1]));
    endtask

    // Drive inputs, take one rising edge, advance the model, compare just after the edge.
    task automatic step(input logic [7:0] raw, input logic en);
        sw_raw    = raw;
        sample_en = en;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic pulse_reset(input logic [7:0] raw);
        @(negedge clk);
        sw_raw  = raw;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_clean", 32'(clean4), 32'h0);
        chk("rst_chg",   32'(chg4),   32'h0);
        chk("rst_busy",  32'(busy4),  32'h0);
        chk("rst_clean1", 32'(clean1), 32'h0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [7:0] raw;

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        sample_en = 1'b0;
        sw_raw    = '0;
        model_reset();
        #12;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) step(8'h00, 1'b1);

        // Clean step to 5A: accepted at edge 5, one changed pulse, busy edges 2..4.
        for (int e = 0; e < 10; e++) begin
            step(8'h5A, 1'b1);
            if (e == 1) chk("step_busy_e1", 32'(busy4), 32'h0);
            if (e == 2) chk("step_busy_e2", 32'(busy4), 32'h1);
            if (e == 4) chk("step_clean_e4", 32'(clean4), 32'h00);
            if (e == 5) chk("step_clean_e5", 32'(clean4), 32'h5A);
            if (e == 5) chk("step_chg_e5", 32'(chg4), 32'h1);
            if (e == 5) chk("step_busy_e5", 32'(busy4), 32'h0);
            if (e == 6) chk("step_chg_e6", 32'(chg4), 32'h0);
            if (e == 0) chk("n1_clean_e0", 32'(clean1), 32'h00);
            if (e == 2) chk("n1_clean_e2", 32'(clean1), 32'h5A);
        end

        // Glitch on bit0 for three cycles from a zero baseline.
        pulse_reset(8'hFF);
        for (int c = 0; c < 4; c++) step(8'h00, 1'b1);
        for (int c = 0; c < 3; c++) step(8'h01, 1'b1);
        for (int c = 0; c < 6; c++) begin
            step(8'h00, 1'b1);
            chk("glitch_chg", 32'(chg4), 32'h0);
        end
        chk("glitch_clean", 32'(clean4), 32'h00);
        chk("glitch_busy", 32'(busy4), 32'h0);

        // Independent bits: bit7 from edge 0, bit0 from edge 2.
        for (int e = 0; e < 10; e++) begin
            step((e >= 2) ? 8'h81 : 8'h80, 1'b1);
            if (e == 4) chk("ind_e4", 32'(clean4), 32'h00);
            if (e == 5) chk("ind_e5", 32'(clean4), 32'h80);
            if (e == 5) chk("ind_chg_e5", 32'(chg4), 32'h1);
            if (e == 6) chk("ind_chg_e6", 32'(chg4), 32'h0);
            if (e == 7) chk("ind_e7", 32'(clean4), 32'h81);
            if (e == 7) chk("ind_chg_e7", 32'(chg4), 32'h1);
        end

        // Strobe gating: one strobe in ten.
        pulse_reset(8'h00);
        for (int c = 0; c < 80; c++) step(8'h0F, (c % 10) == 9);
        chk("gate_clean", 32'(clean4), 32'h0F);

        // Reset mid-count with 33 held: accepted on the sixth edge after release.
        pulse_reset(8'h00);
        for (int c = 0; c < 4; c++) step(8'h00, 1'b1);
        for (int c = 0; c < 4; c++) step(8'h33, 1'b1);
        pulse_reset(8'h33);
        for (int e = 0; e < 8; e++) begin
            step(8'h33, 1'b1);
            if (e == 4) chk("midrst_e4", 32'(clean4), 32'h00);
            if (e == 5) chk("midrst_e5", 32'(clean4), 32'h33);
        end

        // Random: sparse bit changes with random strobes.
        raw = 8'h33;
        for (int c = 0; c < 3000; c++) begin
            raw = raw ^ 8'($urandom & $urandom & $urandom);
            step(raw, $urandom_range(0, 3) != 0);
        end
        // Random: every-cycle toggling bursts; the stability-4 output must not move.
        for (int c = 0; c < 12; c++) step(8'hA5, 1'b1);
        for (int c = 0; c < 200; c++) begin
            raw = (c % 2 == 0) ? 8'h5A : 8'hA5;
            step(raw, 1'b1);
            chk("toggle_chg4", 32'(chg4), 32'h0);
        end
        chk("toggle_clean4", 32'(clean4), 32'hA5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
